dm_store_buffer: RTL
====================

Name: dm_store_buffer

Overview:
- FIFO write buffer between the MEM-stage load/store request and the byte-enable data memory port.
- Decouples stores from the memory write: each store is aligned to a word plus byte enables, queued, and drained one entry per cycle.
- Loads read the memory word combinationally and merge in any pending buffered bytes, so software always sees program-order data.
- Sign/zero extension of load data stays downstream; this block returns the raw merged word.

Parameters:
DEPTH, 4, number of buffer entries; power of two, minimum 2.
PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
req_valid  input  1  MEM stage holds a memory request this cycle.
req_we  input  1  1 = store, 0 = load.
req_part  input  2  access size; `memWord/`memHalf/`memByte encodings from constants.v.
req_addr  input  32  byte address.
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
req_pc  input  32  PC of the requesting instruction, carried for the write trace.
req_stall  output  1  freeze MEM stage and earlier; the request is not accepted.
ld_rdata  output  32  merged raw word for a load; valid in the same cycle as the request.
sb_empty  output  1  no pending entries.
dm_rdata  input  32  memory word at {req_addr[31:2],2'b00} (combinational read port).
dm_we  output  1  drain write strobe.
dm_byteen  output  4  drain byte enables; bit i covers bits [8i+7:8i].
dm_addr  output  32  drain word address, low two bits 0.
dm_wdata  output  32  drain data, lane-aligned.
dm_pc  output  32  PC of the drained store, used by the memory write trace.

Behaviour:
- State: entry array {waddr[31:2], be[3:0], data[31:0], pc[31:0]}, head, tail (PTR_W bits, wrap modulo DEPTH), count (PTR_W+1 bits, 0..DEPTH).
- Reset (async):
  - count=0, head=0, tail=0.
  - All outputs deassert: dm_we=0, dm_byteen=0, dm_addr=0, dm_wdata=0, dm_pc=0, req_stall=0, sb_empty=1.
  - Reset mid-operation discards every pending store; none reach memory.
- Store alignment (combinational):
  - Word: be=4'b1111, data=wdata.
  - Half: be = addr[1] ? 4'b1100 : 4'b0011; data = {2{wdata[15:0]}}.
  - Byte: be = 4'b0001 << addr[1:0]; data = {4{wdata[7:0]}}.
  - Low address bits that a size does not use are ignored; there is no misalignment trap.
- Enqueue: at a rising edge when req_valid & req_we & (count != DEPTH), write the entry at tail, then tail+1.
- Full: req_stall = req_valid & req_we & (count == DEPTH).
  - The stall holds even if a drain happens in the same cycle; the store is accepted the following cycle.
- Drain:
  - dm_we = (count != 0), driven combinationally from the head entry.
  - At each rising edge with count != 0: head+1.
  - The memory commits the entry on that same edge.
- Count update:
  - Enqueue and drain in the same cycle: count unchanged.
  - Enqueue only: +1. Drain only: -1.
- Load merge (combinational; a load never stalls):
  - Start from dm_rdata.
  - Walk valid entries oldest to youngest and overwrite each byte lane whose entry has waddr == req_addr[31:2] and be[i]=1. The youngest entry wins per byte.
  - The head entry being drained this cycle is still included in the merge.
  - When req_valid=0 or req_we=1, ld_rdata = dm_rdata.
- sb_empty = (count == 0). Software sync and the trace end rely on it.
- One request per cycle. req_stall never asserts for loads or when req_valid=0.

Decomposition:
- constants.v (shared): `memWord, `memHalf, `memByte, and the new `SB_DEPTH default.
- Sub-module sb_lane_align: pure combinational mapping of req_part, req_addr[1:0], req_wdata to {be, lane data}. It is reused by the downstream load-extension logic.
- FIFO storage, pointers and the merge loop stay in dm_store_buffer.

Test Plan:
- Reset then one sw of 0x12345678 to 0x10 at pc 0x3000 -> next cycle dm_we=1, dm_addr=0x10, dm_byteen=4'b1111, dm_wdata=0x12345678, dm_pc=0x3000; the cycle after, sb_empty=1.
- sb 0xAB to 0x13, then sh 0xBEEF to 0x12 -> entries be=4'b1000 with data 0xABABABAB, then be=4'b1100 with data 0xBEEFBEEF. A lw 0x10 with dm_rdata=0 while both are pending returns 0xBEEF0000.
- Hold dm-side draining by issuing 5 back-to-back stores with DEPTH=4 from empty -> the 5th is accepted without a stall, because a drain occurs every cycle. A variant starting from count=4 -> req_stall=1 for exactly one cycle, then the store is accepted.
- Load to an address with no pending match while count=3 -> ld_rdata equals dm_rdata exactly (e.g. 0xCAFEF00D).
- Store, plus simultaneous drain, with count=2 -> count stays 2; tail wraps from 3 to 0 with no lost entry. Check the order of dm_addr over the next 2 cycles.
- Assert reset asynchronously mid-cycle with count=3 -> dm_we drops before the next edge, sb_empty=1, and no further writes occur.

Source files
------------

// File: rtl/dm_store_buffer_pkg.sv
// Shared encodings and entry layout for the data-memory store buffer.
package dm_store_buffer_pkg;

   // Access-size encodings carried on req_part.
   localparam logic [1:0] MEM_WORD = 2'd0;
   localparam logic [1:0] MEM_HALF = 2'd1;
   localparam logic [1:0] MEM_BYTE = 2'd2;

   // Default number of buffer entries.
   localparam int SB_DEPTH = 4;

   // One queued store: word address, byte enables, lane-aligned data, PC.
   typedef struct packed {
      logic [29:0] waddr;
      logic [3:0]  be;
      logic [31:0] data;
      logic [31:0] pc;
   } sb_entry_t;

endpackage

// File: rtl/dm_store_buffer_sb_lane_align.sv
// Maps an access size, low address bits and right-aligned store data onto
// word lanes with byte enables. Unused low address bits are ignored.
module sb_lane_align
   import dm_store_buffer_pkg::*;
(
   input  logic [1:0]  part,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] data
);

   // Replicate the datum into every lane and select the lanes it covers.
   always_comb begin
      be   = 4'b1111;
      data = wdata;
      case (part)
         MEM_HALF: begin
            be   = addr_lo[1] ? 4'b1100 : 4'b0011;
            data = {2{wdata[15:0]}};
         end
         MEM_BYTE: begin
            be   = 4'b0001 << addr_lo;
            data = {4{wdata[7:0]}};
         end
         default: begin
            be   = 4'b1111;
            data = wdata;
         end
      endcase
   end

endmodule

// File: rtl/dm_store_buffer.sv
// FIFO write buffer between the MEM stage and the byte-enable data memory.
// Stores are aligned, queued and drained one per cycle; loads read memory
// combinationally and merge pending buffered bytes (youngest wins).
//
// Request handshake: a request is presented with req_valid=1. It is accepted
// at the rising edge unless req_stall=1 in that cycle, in which case the MEM
// stage must hold the identical request until req_stall drops. Only stores
// into a full buffer stall; loads are always accepted and answered in the
// same cycle on ld_rdata.
module dm_store_buffer
   import dm_store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int PTR_W = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_part,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        req_stall,
   output logic [31:0] ld_rdata,
   output logic        sb_empty,
   input  logic [31:0] dm_rdata,
   output logic        dm_we,
   output logic [3:0]  dm_byteen,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [31:0] dm_pc
);

   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

   sb_entry_t        entries [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   count;

   logic [3:0]       al_be;
   logic [31:0]      al_data;
   logic             is_store;
   logic             enq;
   logic             drain;
   logic [PTR_W-1:0] mrg_idx;
   logic [31:0]      merged;
   sb_entry_t        head_entry;

   sb_lane_align u_align (
      .part    (req_part),
      .addr_lo (req_addr[1:0]),
      .wdata   (req_wdata),
      .be      (al_be),
      .data    (al_data)
   );

   assign is_store   = req_valid & req_we;
   assign enq        = is_store & (count != FULL_COUNT);
   assign drain      = (count != '0);
   assign req_stall  = is_store & (count == FULL_COUNT);
   assign sb_empty   = (count == '0);
   assign head_entry = entries[head];

   // Drain port shows the head entry while anything is pending, zeros otherwise.
   assign dm_we     = drain;
   assign dm_byteen = drain ? head_entry.be : 4'b0000;
   assign dm_addr   = drain ? {head_entry.waddr, 2'b00} : 32'd0;
   assign dm_wdata  = drain ? head_entry.data : 32'd0;
   assign dm_pc     = drain ? head_entry.pc : 32'd0;

   // Entry payload; validity is tracked by head/count, so no reset needed.
   always_ff @(posedge clk) begin
      if (enq) begin
         entries[tail] <= '{waddr: req_addr[31:2], be: al_be, data: al_data, pc: req_pc};
      end
   end

   // Pointers and occupancy; the memory commits the head on every edge with count != 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq)   tail <= tail + PTR_W'(1);
         if (drain) head <= head + PTR_W'(1);
         case ({enq, drain})
            2'b10:   count <= count + (PTR_W + 1)'(1);
            2'b01:   count <= count - (PTR_W + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Load merge: walk valid entries oldest to youngest so the youngest byte wins.
   always_comb begin
      merged  = dm_rdata;
      mrg_idx = head;
      for (int k = 0; k < DEPTH; k++) begin
         mrg_idx = head + k[PTR_W-1:0];
         if (((PTR_W + 1)'(k) < count) && (entries[mrg_idx].waddr == req_addr[31:2])) begin
            for (int b = 0; b < 4; b++) begin
               if (entries[mrg_idx].be[b]) merged[8*b +: 8] = entries[mrg_idx].data[8*b +: 8];
            end
         end
      end
   end

   assign ld_rdata = (req_valid & ~req_we) ? merged : dm_rdata;

endmodule
